fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage directly upstream of decode (main/ALU decoders). Owns the PC and issues
//  in-order requests to instruction memory over a valid/ready port. Buffers responses in a small FIFO
//  and presents {instr, pc, pc+4} to decode over a valid/ready handshake. Discards wrong-path
//  instructions on a redirect (branch/jump target from execute).
// PARAMETERS
//  XLEN      32            address/data width
//  RESET_PC  32'h0000_0000 first fetch address after reset
//  DEPTH     2             response FIFO entries; also max in-flight + buffered instructions (>=2)
// PORTS
//  clk             in   1     single clock, rising edge
//  rst_n           in   1     asynchronous, active-low reset
//  imem_req_valid  out  1     fetch request valid
//  imem_req_ready  in   1     memory accepts request
//  imem_req_addr   out  XLEN  fetch address (= PC)
//  imem_rsp_valid  in   1     response valid (in order, >=1 cycle after accept, no backpressure)
//  imem_rsp_data   in   32    instruction word
//  redirect_valid  in   1     flush + load new PC
//  redirect_pc     in   XLEN  new PC; bits [1:0] ignored (forced 2'b00)
//  id_valid        out  1     instruction available to decode
//  id_ready        in   1     decode accepts
//  id_instr        out  32    instruction (opcode field feeds main decoder)
//  id_pc           out  XLEN  address of id_instr
//  id_pc_plus4     out  XLEN  id_pc + 4
// BEHAVIOUR
//  Reset (async assert, sync deassert use): pc=RESET_PC, fifo empty, outstanding=0, drop_cnt=0,
//   state=BOOT; imem_req_valid=0, id_valid=0, id_* = 0.
//  FSM: BOOT -> FETCH unconditionally one cycle after rst_n deasserts (no request in BOOT).
//   FETCH persists; no other states.
//  Request: imem_req_valid = (state==FETCH) & !redirect_valid &
//   (outstanding + count - id_fire) < DEPTH. id_fire = id_valid & id_ready.
//   On req accept: store pc in a per-request tag queue (depth DEPTH); pc <= pc+4 (mod 2^XLEN, wraps).
//  Response: if drop_cnt>0, drop_cnt--, data discarded; else push {data, tagged pc} into FIFO.
//   outstanding += req_accept - rsp_valid each cycle.
//   rsp_valid with outstanding==0 is a protocol error (assertion).
//  Output: id_* driven from FIFO head (registered storage); id_valid = count!=0 & !redirect_valid.
//   Head pops on id_fire. Push and pop in the same cycle are legal at any count, including full.
//  Latency: req accepted cycle t, rsp cycle t+1 -> id_valid cycle t+2. Steady throughput is 1/cycle
//   with 1-cycle memory and id_ready=1.
//  Full: credit rule guarantees no FIFO overflow; id_ready=0 holds head stable
//   (id_* unchanged while id_valid & !id_ready).
//  Redirect (priority over everything): pc <= {redirect_pc[XLEN-1:2],2'b00}; FIFO flushed;
//   drop_cnt <= outstanding - rsp_valid (responses arriving this cycle are dropped immediately);
//   no request issued and no id_fire that cycle. New-path requests start the next cycle while
//   stale responses still drain.
//  Back-to-back redirects: each reloads pc; drop_cnt accumulates correctly via the same formula.
//  Reset mid-operation: all state cleared immediately; late memory responses after reset are
//   the memory's responsibility (memory shares rst_n).
// TESTING
//  1 Reset release, imem 1-cycle latency, id_ready=1 -> first req addr 0x0 in cycle 2; id_pc
//    sequence 0x0,0x4,0x8 on consecutive cycles.
//  2 id_ready=0 for 10 cycles -> at most DEPTH(2) instr buffered; head held; on release the
//    in-order pc stream continues with no loss/duplication.
//  3 Redirect to 0x100 with 2 in flight -> both responses dropped; next id_pc=0x100, then 0x104.
//  4 redirect_pc=0x203 -> fetch addr 0x200; redirect same cycle as rsp_valid & id_fire -> rsp
//    dropped, head not consumed.
//  5 RESET_PC=0xFFFF_FFFC -> id_pc 0xFFFF_FFFC then 0x0; id_pc_plus4 wraps to 0x0.
//  6 rst_n pulsed low mid-stream with FIFO full -> outputs 0 asynchronously; restart at RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues in-order imem requests under a credit limit,
// buffers responses and presents {instr, pc, pc+4} to decode; redirects flush and drop stale responses.
module fetch_stage #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}},
  parameter int unsigned     DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [31:0]     id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc_plus4
);

  localparam int unsigned     PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned     CW       = $clog2(DEPTH + 1);
  localparam logic [PW-1:0]   LAST_IDX = PW'(DEPTH - 1);
  localparam logic [XLEN-1:0] PC_STEP  = XLEN'(32'd4);
  localparam logic [0:0]      ST_BOOT  = 1'b0;
  localparam logic [0:0]      ST_FETCH = 1'b1;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_IDX) ? {PW{1'b0}} : p + PW'(1'b1);
  endfunction

  logic [0:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   out_q, out_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   tag_rd_q, tag_rd_d;
  logic [PW-1:0]   tag_wr_q, tag_wr_d;

  logic [XLEN-1:0] tag_q        [DEPTH];
  logic [31:0]     fifo_instr_q [DEPTH];
  logic [XLEN-1:0] fifo_pc_q    [DEPTH];
  logic [XLEN-1:0] fifo_pc4_q   [DEPTH];

  logic            id_fire_s;
  logic            req_accept_s;
  logic            push_s;
  logic [CW:0]     inflight_s;
  logic            unused_ok;

  // Credit counts everything in flight or buffered, minus the entry leaving this cycle.
  assign id_fire_s      = id_valid & id_ready;
  assign id_valid       = (cnt_q != {CW{1'b0}}) & ~redirect_valid;
  assign inflight_s     = {1'b0, out_q} + {1'b0, cnt_q} - (CW+1)'(id_fire_s);
  assign imem_req_valid = (state_q == ST_FETCH) & ~redirect_valid & (inflight_s < (CW+1)'(DEPTH));
  assign imem_req_addr  = pc_q;
  assign req_accept_s   = imem_req_valid & imem_req_ready;
  assign push_s         = imem_rsp_valid & ~redirect_valid & (drop_q == {CW{1'b0}});

  assign id_instr       = fifo_instr_q[rd_ptr_q];
  assign id_pc          = fifo_pc_q[rd_ptr_q];
  assign id_pc_plus4    = fifo_pc4_q[rd_ptr_q];
  assign unused_ok      = &{1'b0, redirect_pc[1:0]};

  // Next-state logic for PC, counters, pointers and boot FSM.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    out_d    = out_q + CW'(req_accept_s) - CW'(imem_rsp_valid);
    drop_d   = drop_q;
    cnt_d    = cnt_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    tag_wr_d = req_accept_s ? ptr_inc(tag_wr_q) : tag_wr_q;
    tag_rd_d = imem_rsp_valid ? ptr_inc(tag_rd_q) : tag_rd_q;

    case (state_q)
      ST_BOOT:  state_d = ST_FETCH;
      ST_FETCH: state_d = ST_FETCH;
      default:  state_d = ST_BOOT;
    endcase

    if (redirect_valid) begin
      // Everything still outstanding belongs to the old path, except a response landing now.
      pc_d     = {redirect_pc[XLEN-1:2], 2'b00};
      drop_d   = out_q - CW'(imem_rsp_valid);
      cnt_d    = {CW{1'b0}};
      rd_ptr_d = {PW{1'b0}};
      wr_ptr_d = {PW{1'b0}};
    end else begin
      if (req_accept_s) begin
        pc_d = pc_q + PC_STEP;
      end else begin
        pc_d = pc_q;
      end
      if (imem_rsp_valid && (drop_q != {CW{1'b0}})) begin
        drop_d = drop_q - CW'(1'b1);
      end else begin
        drop_d = drop_q;
      end
      cnt_d    = cnt_q + CW'(push_s) - CW'(id_fire_s);
      rd_ptr_d = id_fire_s ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      wr_ptr_d = push_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_BOOT;
      pc_q     <= RESET_PC;
      out_q    <= {CW{1'b0}};
      drop_q   <= {CW{1'b0}};
      cnt_q    <= {CW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      wr_ptr_q <= {PW{1'b0}};
      tag_rd_q <= {PW{1'b0}};
      tag_wr_q <= {PW{1'b0}};
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      out_q    <= out_d;
      drop_q   <= drop_d;
      cnt_q    <= cnt_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      tag_rd_q <= tag_rd_d;
      tag_wr_q <= tag_wr_d;
    end
  end

  // Request tag queue and response FIFO storage; cleared so decode sees zeros after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        tag_q[i]        <= {XLEN{1'b0}};
        fifo_instr_q[i] <= 32'h0000_0000;
        fifo_pc_q[i]    <= {XLEN{1'b0}};
        fifo_pc4_q[i]   <= {XLEN{1'b0}};
      end
    end else begin
      if (req_accept_s) begin
        tag_q[tag_wr_q] <= pc_q;
      end
      if (push_s) begin
        fifo_instr_q[wr_ptr_q] <= imem_rsp_data;
        fifo_pc_q[wr_ptr_q]    <= tag_q[tag_rd_q];
        fifo_pc4_q[wr_ptr_q]   <= tag_q[tag_rd_q] + PC_STEP;
      end
    end
  end

  // Memory must never answer a request that was not accepted; credits must prevent overflow.
  a_rsp_has_req: assert property (@(posedge clk) disable iff (!rst_n)
    !(imem_rsp_valid && (out_q == {CW{1'b0}})));
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push_s && !id_fire_s && (cnt_q == CW'(DEPTH))));

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: behavioural memory with variable latency, a PC/instruction scoreboard,
// a table of redirect vectors and hand-written boot, stall, back-to-back-redirect and reset sequences.
module tb_fetch_stage;

  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] RPC2  = 32'hFFFF_FFFC;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_req_addr, imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid, id_ready;
  logic [31:0] id_instr, id_pc, id_pc_plus4;

  logic        req_valid2, req_ready2, rsp_valid2, redirect2, id_valid2, id_ready2;
  logic [31:0] req_addr2, rsp_data2, redirect_pc2, id_instr2, id_pc2, id_pc4_2;

  typedef struct { int unsigned due; logic [31:0] addr; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
  typedef struct { int unsigned lat; logic [31:0] rpc; logic [31:0] pc0; logic [31:0] pc1; } vec_t;

  mreq_t       mem_q[$];
  exp_t        exp_q[$];
  int          total = 0;
  int          bad = 0;
  int unsigned cyc = 0;
  int unsigned lat = 1;
  int unsigned last_due = 0;
  logic [31:0] exp_pc, exp2_pc;
  logic        acc2;
  logic [31:0] addr2;
  logic        hold_q;
  logic [31:0] hold_pc, hold_instr;
  logic        s_req_valid, s_id_valid, s_fire;
  logic [31:0] s_req_addr, s_id_pc, s2_id_pc, s2_id_pc4;

  fetch_stage #(.XLEN(32), .RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc), .id_pc_plus4(id_pc_plus4)
  );

  fetch_stage #(.XLEN(32), .RESET_PC(RPC2), .DEPTH(DEPTH)) u_dut_wrap (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(req_valid2), .imem_req_ready(req_ready2), .imem_req_addr(req_addr2),
    .imem_rsp_valid(rsp_valid2), .imem_rsp_data(rsp_data2),
    .redirect_valid(redirect2), .redirect_pc(redirect_pc2),
    .id_valid(id_valid2), .id_ready(id_ready2), .id_instr(id_instr2), .id_pc(id_pc2), .id_pc_plus4(id_pc4_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_0033;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_ok(input string name, input bit ok, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic reset_model();
    mem_q.delete();
    exp_q.delete();
    exp_pc         = 32'h0000_0000;
    exp2_pc        = RPC2;
    last_due       = 0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0000_0000;
    rsp_valid2     = 1'b0;
    rsp_data2      = 32'h0000_0000;
    acc2           = 1'b0;
    addr2          = 32'h0000_0000;
    hold_q         = 1'b0;
  endtask

  task automatic observe();
    exp_t        e;
    mreq_t       m;
    s_req_valid = imem_req_valid;
    s_req_addr  = imem_req_addr;
    s_id_valid  = id_valid;
    s_id_pc     = id_pc;
    s_fire      = id_valid && id_ready;
    s2_id_pc    = id_pc2;
    s2_id_pc4   = id_pc4_2;
    if (redirect_valid) begin
      chk("redir_no_req", {31'd0, imem_req_valid}, 32'd0);
      chk("redir_no_id", {31'd0, id_valid}, 32'd0);
      exp_q.delete();
      exp_pc = {redirect_pc[31:2], 2'b00};
    end else begin
      if (hold_q && id_valid) begin
        chk("hold_pc", id_pc, hold_pc);
        chk("hold_instr", id_instr, hold_instr);
      end
      if (s_fire) begin
        if (exp_q.size() == 0) begin
          chk_ok("id_spurious", 1'b0, id_pc, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("id_pc", id_pc, e.pc);
          chk("id_instr", id_instr, e.instr);
          chk("id_pc_plus4", id_pc_plus4, e.pc + 32'd4);
        end
      end
      if (imem_req_valid && imem_req_ready) begin
        chk("req_addr", imem_req_addr, exp_pc);
        exp_q.push_back('{pc: exp_pc, instr: instr_of(exp_pc)});
        exp_pc = exp_pc + 32'd4;
      end
      chk_ok("credit", exp_q.size() <= DEPTH, exp_q.size(), DEPTH);
    end
    if (imem_req_valid && imem_req_ready) begin
      m.addr = imem_req_addr;
      m.due  = cyc + lat;
      if (m.due <= last_due) m.due = last_due + 1;
      last_due = m.due;
      mem_q.push_back(m);
    end
    hold_q     = id_valid && !id_ready && !redirect_valid;
    hold_pc    = id_pc;
    hold_instr = id_instr;
    if (id_valid2) begin
      chk("wrap_id_pc", id_pc2, exp2_pc);
      chk("wrap_id_pc_plus4", id_pc4_2, exp2_pc + 32'd4);
      chk("wrap_id_instr", id_instr2, instr_of(exp2_pc));
      exp2_pc = exp2_pc + 32'd4;
    end
    acc2  = req_valid2;
    addr2 = req_addr2;
  endtask

  task automatic drive_mem();
    mreq_t m;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      m = mem_q.pop_front();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = instr_of(m.addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0000_0000;
    end
    rsp_valid2 = acc2;
    rsp_data2  = instr_of(addr2);
    acc2       = 1'b0;
  endtask

  task automatic tick();
    #1;
    observe();
    @(posedge clk);
    #1;
    cyc++;
    drive_mem();
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_req_valid"}, {31'd0, imem_req_valid}, 32'd0);
    chk({name, "_req_addr"}, imem_req_addr, 32'h0000_0000);
    chk({name, "_id_valid"}, {31'd0, id_valid}, 32'd0);
    chk({name, "_id_instr"}, id_instr, 32'h0000_0000);
    chk({name, "_id_pc"}, id_pc, 32'h0000_0000);
    chk({name, "_id_pc_plus4"}, id_pc_plus4, 32'h0000_0000);
    chk({name, "_wrap_id_valid"}, {31'd0, id_valid2}, 32'd0);
    chk({name, "_wrap_req_addr"}, req_addr2, RPC2);
  endtask

  // Boot: no request in the first cycle, first request at RESET_PC next, decode two cycles later.
  task automatic check_boot();
    tick(); chk("boot_no_req", {31'd0, s_req_valid}, 32'd0);
    tick(); chk("first_req_valid", {31'd0, s_req_valid}, 32'd1);
            chk("first_req_addr", s_req_addr, 32'h0000_0000);
    tick(); chk("no_id_before_latency", {31'd0, s_id_valid}, 32'd0);
    tick(); chk("first_id_valid", {31'd0, s_id_valid}, 32'd1);
            chk("first_id_pc", s_id_pc, 32'h0000_0000);
            chk("wrap_first_pc", s2_id_pc, 32'hFFFF_FFFC);
            chk("wrap_first_plus4", s2_id_pc4, 32'h0000_0000);
    tick(); chk("id_pc_seq1", s_id_pc, 32'h0000_0004);
            chk("wrap_second_pc", s2_id_pc, 32'h0000_0000);
    tick(); chk("id_pc_seq2", s_id_pc, 32'h0000_0008);
  endtask

  initial begin
    vec_t        vecs [4];
    logic [31:0] got_pc [2];
    int          got;
    int          n;

    vecs[0] = '{lat: 3, rpc: 32'h0000_0100, pc0: 32'h0000_0100, pc1: 32'h0000_0104};
    vecs[1] = '{lat: 1, rpc: 32'h0000_0203, pc0: 32'h0000_0200, pc1: 32'h0000_0204};
    vecs[2] = '{lat: 2, rpc: 32'hFFFF_FFFE, pc0: 32'hFFFF_FFFC, pc1: 32'h0000_0000};
    vecs[3] = '{lat: 1, rpc: 32'h1234_567B, pc0: 32'h1234_5678, pc1: 32'h1234_567C};

    rst_n          = 1'b1;
    imem_req_ready = 1'b1;
    id_ready       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0000_0000;
    req_ready2     = 1'b1;
    id_ready2      = 1'b1;
    redirect2      = 1'b0;
    redirect_pc2   = 32'h0000_0000;
    reset_model();
    #1 rst_n = 1'b0;
    #2 check_reset_outputs("por");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check_boot();

    n = 0;
    repeat (20) begin
      tick();
      if (s_fire) n++;
    end
    chk("throughput", n, 32'd20);

    id_ready = 1'b0;
    repeat (10) tick();
    chk("stall_fill", exp_q.size(), DEPTH);
    chk("stall_valid", {31'd0, s_id_valid}, 32'd1);
    id_ready = 1'b1;
    repeat (10) tick();

    for (int i = 0; i < 4; i++) begin
      lat = vecs[i].lat;
      repeat (8) tick();
      if (vecs[i].lat >= 3) begin
        for (int k = 0; k < 12 && (mem_q.size() + imem_rsp_valid) < 2; k++) tick();
        chk_ok("two_in_flight", (mem_q.size() + imem_rsp_valid) >= 2, mem_q.size() + imem_rsp_valid, 2);
      end else if (vecs[i].lat == 1) begin
        chk("redir_with_rsp", {31'd0, imem_rsp_valid}, 32'd1);
      end
      redirect_valid = 1'b1;
      redirect_pc    = vecs[i].rpc;
      tick();
      redirect_valid = 1'b0;
      got = 0;
      for (int k = 0; k < 40 && got < 2; k++) begin
        tick();
        if (s_fire) begin
          got_pc[got] = s_id_pc;
          got++;
        end
      end
      if (got < 2) begin
        chk_ok("redir_timeout", 1'b0, got, 2);
      end else begin
        chk("redir_pc0", got_pc[0], vecs[i].pc0);
        chk("redir_pc1", got_pc[1], vecs[i].pc1);
      end
    end

    lat = 3;
    repeat (8) tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0300;
    tick();
    redirect_pc    = 32'h0000_0400;
    tick();
    redirect_valid = 1'b0;
    got = 0;
    for (int k = 0; k < 40 && got < 1; k++) begin
      tick();
      if (s_fire) begin
        got_pc[0] = s_id_pc;
        got++;
      end
    end
    if (got < 1) chk_ok("b2b_timeout", 1'b0, got, 1);
    else chk("b2b_redir_pc", got_pc[0], 32'h0000_0400);

    for (int k = 0; k < 300; k++) begin
      id_ready       = ($urandom_range(0, 3) != 0);
      imem_req_ready = ($urandom_range(0, 3) != 0);
      lat            = $urandom_range(1, 3);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = $urandom;
      tick();
      redirect_valid = 1'b0;
    end
    id_ready       = 1'b1;
    imem_req_ready = 1'b1;
    lat            = 1;
    repeat (10) tick();

    id_ready = 1'b0;
    repeat (8) tick();
    chk("full_before_reset", exp_q.size(), DEPTH);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("mid_reset");
    reset_model();
    id_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check_boot();
    repeat (10) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
